// File: rtl/descrambler_pkg.sv
// Types and symbol constants shared by the receive descrambler sequencer and the scrambler.
package descrambler_pkg;

    typedef enum logic [2:0] {
        ST_OFF      = 3'd0,
        ST_HDR      = 3'd1,
        ST_DATA_BLK = 3'd2,
        ST_OS_BLK   = 3'd3,
        ST_SKIP_BLK = 3'd4
    } blk_state_t;

    typedef enum logic [2:0] {
        OS_OTHER = 3'd0,
        OS_SKP   = 3'd1,
        OS_EIEOS = 3'd2,
        OS_EIOS  = 3'd3,
        OS_SDS   = 3'd4
    } os_type_t;

    localparam logic [7:0] DEF_EIEOS_SYM = 8'h00;
    localparam logic [7:0] DEF_SKP_SYM   = 8'hAA;
    localparam logic [7:0] DEF_EIOS_SYM  = 8'h66;
    localparam logic [7:0] DEF_SDS_SYM   = 8'hE1;
    localparam logic [7:0] DEF_COM_K     = 8'hBC;
    localparam logic [7:0] DEF_SKP_K     = 8'h1C;

    localparam logic [1:0] HDR_DATA = 2'b01;
    localparam logic [1:0] HDR_OS   = 2'b10;

    function automatic logic [3:0] lane_mask(input logic [5:0] width);
        case (width)
            6'd8:    lane_mask = 4'b0001;
            6'd16:   lane_mask = 4'b0011;
            6'd32:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [4:0] lane_count(input logic [5:0] width);
        case (width)
            6'd8:    lane_count = 5'd1;
            6'd16:   lane_count = 5'd2;
            6'd32:   lane_count = 5'd4;
            default: lane_count = 5'd0;
        endcase
    endfunction

    // Illegal widths select the widest LFSR
    function automatic logic [1:0] lfsr_sel_of(input logic [5:0] width);
        case (width)
            6'd8:    lfsr_sel_of = 2'd0;
            6'd16:   lfsr_sel_of = 2'd1;
            default: lfsr_sel_of = 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/descrambler_block_sequencer_os_symbol_decode.sv
// Classifies the lane-0 byte of an ordered-set block (Gen3+ only).
module os_symbol_decode
    import descrambler_pkg::*;
#(
    parameter logic [7:0] EIEOS_SYM = DEF_EIEOS_SYM,
    parameter logic [7:0] SKP_SYM   = DEF_SKP_SYM,
    parameter logic [7:0] EIOS_SYM  = DEF_EIOS_SYM,
    parameter logic [7:0] SDS_SYM   = DEF_SDS_SYM
)(
    input  logic [7:0] sym,
    input  logic [2:0] gen,
    output logic [2:0] os_type
);

    // Symbol-0 lookup; anything unrecognised descrambles like a TS
    always_comb begin
        os_type = OS_OTHER;
        if (gen < 3'd3) begin
            os_type = OS_OTHER;
        end else begin
            case (sym)
                EIEOS_SYM: os_type = OS_EIEOS;
                SKP_SYM:   os_type = OS_SKP;
                EIOS_SYM:  os_type = OS_EIOS;
                SDS_SYM:   os_type = OS_SDS;
                default:   os_type = OS_OTHER;
            endcase
        end
    end

endmodule

// File: rtl/descrambler_block_sequencer.sv
// Block-tracking control FSM for the receive descrambler; outputs are Mealy on the
// current PIPE beat so the descrambler sees them with zero latency.
module descrambler_block_sequencer
    import descrambler_pkg::*;
#(
    parameter int         BLOCK_SYMS = 16,
    parameter logic [7:0] EIEOS_SYM  = DEF_EIEOS_SYM,
    parameter logic [7:0] SKP_SYM    = DEF_SKP_SYM,
    parameter logic [7:0] EIOS_SYM   = DEF_EIOS_SYM,
    parameter logic [7:0] SDS_SYM    = DEF_SDS_SYM,
    parameter logic [7:0] COM_K      = DEF_COM_K,
    parameter logic [7:0] SKP_K      = DEF_SKP_K
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        turnOff,
    input  logic [2:0]  GEN,
    input  logic [5:0]  PIPEWIDTH,
    input  logic        PIPEDataValid,
    input  logic [1:0]  PIPESyncHeader,
    input  logic [31:0] PIPEData,
    input  logic [3:0]  PIPEDataK,
    output logic        patternReset,
    output logic [3:0]  advance,
    output logic [3:0]  descramblingEnable,
    output logic [1:0]  lfsrSel,
    output logic        blockStart,
    output logic [3:0]  symIndex,
    output logic        blockError
);

    blk_state_t state_r, state_nxt_s, blk_kind_s;
    os_type_t   os_type_r, os_type_nxt_s, os_cur_s;
    logic [2:0] os_dec_s;
    logic [3:0] sym_cnt_r, sym_cnt_nxt_s, lane_mask_s;
    logic [4:0] sym_sum_s;
    logic       gen3_s, beat_s, blk_end_s, hdr_bad_s, active_s;

    assign lane_mask_s = lane_mask(PIPEWIDTH);
    assign gen3_s      = (GEN >= 3'd3);
    assign beat_s      = PIPEDataValid && (lane_mask_s != 4'd0);
    assign sym_sum_s   = {1'b0, sym_cnt_r} + lane_count(PIPEWIDTH);
    assign blk_end_s   = (sym_sum_s >= 5'(BLOCK_SYMS));
    assign active_s    = !reset && !turnOff && (state_r != ST_OFF);
    assign lfsrSel     = lfsr_sel_of(PIPEWIDTH);

    os_symbol_decode #(
        .EIEOS_SYM (EIEOS_SYM),
        .SKP_SYM   (SKP_SYM),
        .EIOS_SYM  (EIOS_SYM),
        .SDS_SYM   (SDS_SYM)
    ) u_os_decode (
        .sym     (PIPEData[7:0]),
        .gen     (GEN),
        .os_type (os_dec_s)
    );

    // Block kind of the current beat: from the sync header at symbol 0, else the latched state
    always_comb begin
        hdr_bad_s  = 1'b0;
        blk_kind_s = state_r;
        os_cur_s   = os_type_r;
        if (state_r == ST_HDR) begin
            os_cur_s = os_type_t'(os_dec_s);
            case (PIPESyncHeader)
                HDR_DATA: blk_kind_s = ST_DATA_BLK;
                HDR_OS:   blk_kind_s = ST_OS_BLK;
                default: begin
                    blk_kind_s = ST_SKIP_BLK;
                    hdr_bad_s  = 1'b1;
                end
            endcase
        end else begin
            blk_kind_s = state_r;
        end
    end

    // State, symbol counter and OS type registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_HDR;
            sym_cnt_r <= 4'd0;
            os_type_r <= OS_OTHER;
        end else begin
            state_r   <= state_nxt_s;
            sym_cnt_r <= sym_cnt_nxt_s;
            os_type_r <= os_type_nxt_s;
        end
    end

    // Next-state logic; a block ending on this beat always returns to HDR
    always_comb begin
        state_nxt_s   = state_r;
        sym_cnt_nxt_s = sym_cnt_r;
        os_type_nxt_s = os_type_r;
        if (turnOff) begin
            state_nxt_s = ST_OFF;
        end else if (state_r == ST_OFF) begin
            state_nxt_s   = ST_HDR;
            sym_cnt_nxt_s = 4'd0;
        end else if (!beat_s) begin
            state_nxt_s = state_r;
        end else if (!gen3_s) begin
            state_nxt_s   = ST_DATA_BLK;
            sym_cnt_nxt_s = 4'd0;
        end else begin
            os_type_nxt_s = os_cur_s;
            if (blk_end_s) begin
                state_nxt_s   = ST_HDR;
                sym_cnt_nxt_s = 4'd0;
            end else begin
                state_nxt_s   = blk_kind_s;
                sym_cnt_nxt_s = sym_sum_s[3:0];
            end
        end
    end

    // Per-lane enables, LFSR control and block status for the current beat
    always_comb begin
        patternReset       = 1'b0;
        advance            = 4'd0;
        descramblingEnable = 4'd0;
        blockStart         = 1'b0;
        symIndex           = 4'd0;
        blockError         = 1'b0;
        if (!active_s) begin
            symIndex = 4'd0;
        end else if (!gen3_s) begin
            for (int i = 0; i < 4; i++) begin
                if (beat_s && lane_mask_s[i]) begin
                    if (!PIPEDataK[i]) begin
                        descramblingEnable[i] = 1'b1;
                        advance[i]            = 1'b1;
                    end else begin
                        advance[i] = (PIPEData[8*i +: 8] != SKP_K);
                        if (PIPEData[8*i +: 8] == COM_K) begin
                            if (i == 0) begin
                                patternReset = 1'b1;
                            end else begin
                                blockError = 1'b1;
                            end
                        end else begin
                            blockError = blockError;
                        end
                    end
                end else begin
                    advance[i] = 1'b0;
                end
            end
        end else begin
            symIndex = sym_cnt_r;
            if (beat_s) begin
                blockStart = (state_r == ST_HDR);
                blockError = (state_r == ST_HDR) && hdr_bad_s;
                case (blk_kind_s)
                    ST_DATA_BLK: begin
                        advance            = lane_mask_s;
                        descramblingEnable = lane_mask_s;
                    end
                    ST_OS_BLK: begin
                        case (os_cur_s)
                            OS_SKP: advance = 4'd0;
                            OS_EIEOS: begin
                                advance      = lane_mask_s;
                                patternReset = blk_end_s;
                            end
                            OS_EIOS, OS_SDS: advance = lane_mask_s;
                            default: begin
                                // Symbol 0 of a TS carries the OS identifier in the clear
                                advance            = lane_mask_s;
                                descramblingEnable = lane_mask_s & ~{3'b000, (sym_cnt_r == 4'd0)};
                            end
                        endcase
                    end
                    default: advance = 4'd0;
                endcase
            end else begin
                blockStart = 1'b0;
            end
        end
    end

endmodule
